// File: rtl/reg_file_sb.sv
// Parametrised register file with two registered read ports, one write-back
// port, write-to-read bypass and a per-register busy scoreboard.
module reg_file_sb #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter bit          R0_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              ra_busy,
    output logic              rb_busy,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              alloc_err,
    output logic              wb_err,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] ra_data_q, ra_data_d, rb_data_q, rb_data_d;
    logic              ra_busy_q, ra_busy_d, rb_busy_q, rb_busy_d;
    logic              alloc_err_q, alloc_err_d, wb_err_q, wb_err_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

    logic wr_ok, alloc_ok;
    logic ra_zero, rb_zero;

    always_comb begin
        wr_ok    = wr_en    && !(R0_ZERO && (wr_addr    == '0));
        alloc_ok = alloc_en && !(R0_ZERO && (alloc_addr == '0));
        ra_zero  = R0_ZERO && (ra_addr == '0);
        rb_zero  = R0_ZERO && (rb_addr == '0);
    end

    // Alloc is applied after write-back so a same-cycle alloc keeps the entry busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok)
            busy_d[wr_addr] = 1'b0;
        if (alloc_ok)
            busy_d[alloc_addr] = 1'b1;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[i]);
    end

    always_comb begin
        alloc_err_d = alloc_ok && busy_q[alloc_addr];
        wb_err_d    = wr_ok && !busy_q[wr_addr];
    end

    always_comb begin
        ra_data_d = ra_data_q;
        rb_data_d = rb_data_q;
        ra_busy_d = ra_busy_q;
        rb_busy_d = rb_busy_q;
        if (rd_en) begin
            if (ra_zero)
                ra_data_d = '0;
            else if (wr_ok && (wr_addr == ra_addr))
                ra_data_d = wr_data;
            else
                ra_data_d = rf_q[ra_addr];

            if (rb_zero)
                rb_data_d = '0;
            else if (wr_ok && (wr_addr == rb_addr))
                rb_data_d = wr_data;
            else
                rb_data_d = rf_q[rb_addr];

            ra_busy_d = busy_d[ra_addr] && !ra_zero;
            rb_busy_d = busy_d[rb_addr] && !rb_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                rf_q[i] <= '0;
            busy_q      <= '0;
            ra_data_q   <= '0;
            rb_data_q   <= '0;
            ra_busy_q   <= 1'b0;
            rb_busy_q   <= 1'b0;
            alloc_err_q <= 1'b0;
            wb_err_q    <= 1'b0;
            busy_cnt_q  <= '0;
        end else begin
            if (wr_ok)
                rf_q[wr_addr] <= wr_data;
            busy_q      <= busy_d;
            ra_data_q   <= ra_data_d;
            rb_data_q   <= rb_data_d;
            ra_busy_q   <= ra_busy_d;
            rb_busy_q   <= rb_busy_d;
            alloc_err_q <= alloc_err_d;
            wb_err_q    <= wb_err_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign ra_data   = ra_data_q;
    assign rb_data   = rb_data_q;
    assign ra_busy   = ra_busy_q;
    assign rb_busy   = rb_busy_q;
    assign alloc_err = alloc_err_q;
    assign wb_err    = wb_err_q;
    assign busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one instance with hardwired R0, one without,
// both driven by the same stimulus.
module tb_reg_file_sb;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          reset, rd_en, alloc_en, wr_en;
    logic [AW-1:0] ra_addr, rb_addr, alloc_addr, wr_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] ra_data, rb_data, ra_data0, rb_data0;
    logic          ra_busy, rb_busy, ra_busy0, rb_busy0;
    logic          alloc_err, wb_err, alloc_err0, wb_err0;
    logic [AW:0]   busy_cnt, busy_cnt0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .R0_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data),
        .ra_busy(ra_busy), .rb_busy(rb_busy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_err(alloc_err), .wb_err(wb_err), .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .R0_ZERO(1'b0)) dut0 (
        .clk(clk), .reset(reset), .rd_en(rd_en),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data0), .rb_data(rb_data0),
        .ra_busy(ra_busy0), .rb_busy(rb_busy0),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alloc_err(alloc_err0), .wb_err(wb_err0), .busy_cnt(busy_cnt0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        rd_en    = 1'b0;
        alloc_en = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
        rd_en   = 1'b1;
        ra_addr = a;
        rb_addr = b;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic alloc(input logic [AW-1:0] a);
        alloc_en   = 1'b1;
        alloc_addr = a;
    endtask

    initial begin
        idle();
        ra_addr = '0; rb_addr = '0; alloc_addr = '0; wr_addr = '0; wr_data = '0;
        #1;
        // Reset with a write and alloc presented; neither may stick.
        reset = 1'b1;
        wr(4'd3, 8'h77);
        alloc(4'd3);
        tick(); tick();

        idle(); rd(4'd3, 4'd15); tick();
        check("rst_ra_data", ra_data, 0);
        check("rst_rb_data", rb_data, 0);
        check("rst_ra_busy", ra_busy, 0);
        check("rst_rb_busy", rb_busy, 0);
        check("rst_busy_cnt", busy_cnt, 0);
        check("rst_alloc_err", alloc_err, 0);
        check("rst_wb_err", wb_err, 0);

        idle(); wr(4'd5, 8'hA5); tick();
        check("wr5_wb_err", wb_err, 1);
        idle(); rd(4'd5, 4'd3); tick();
        check("rd5_data", ra_data, 8'hA5);
        check("rd3_data", rb_data, 0);
        check("rd5_wb_err_clr", wb_err, 0);

        idle(); wr(4'd7, 8'h3C); rd(4'd7, 4'd7); tick();
        check("byp_ra", ra_data, 8'h3C);
        check("byp_rb", rb_data, 8'h3C);

        idle(); wr(4'd7, 8'h55); ra_addr = 4'd5; tick();
        check("hold_ra", ra_data, 8'h3C);
        check("hold_rb", rb_data, 8'h3C);

        idle(); alloc(4'd4); tick();
        check("alloc4_cnt", busy_cnt, 1);
        check("alloc4_err", alloc_err, 0);
        idle(); rd(4'd4, 4'd7); tick();
        check("rd4_busy", ra_busy, 1);
        check("rd7_data", rb_data, 8'h55);
        check("rd7_busy", rb_busy, 0);
        idle(); alloc(4'd4); tick();
        check("realloc4_err", alloc_err, 1);
        check("realloc4_cnt", busy_cnt, 1);
        idle(); tick();
        check("realloc4_err_pulse", alloc_err, 0);

        idle(); wr(4'd4, 8'h11); rd(4'd4, 4'd5); tick();
        check("wb4_ra_busy", ra_busy, 0);
        check("wb4_ra_data", ra_data, 8'h11);
        check("wb4_rb_data", rb_data, 8'hA5);
        check("wb4_cnt", busy_cnt, 0);
        check("wb4_wb_err", wb_err, 0);

        idle(); wr(4'd9, 8'h99); tick();
        check("wb9_err", wb_err, 1);
        idle(); rd(4'd9, 4'd9); tick();
        check("wb9_err_pulse", wb_err, 0);
        check("rd9_data", ra_data, 8'h99);

        idle(); alloc(4'd2); wr(4'd2, 8'h22); tick();
        check("aw2_cnt", busy_cnt, 1);
        check("aw2_wb_err", wb_err, 1);
        check("aw2_alloc_err", alloc_err, 0);
        idle(); rd(4'd2, 4'd2); tick();
        check("aw2_busy", ra_busy, 1);
        check("aw2_data", ra_data, 8'h22);

        idle(); wr(4'd0, 8'hFF); alloc(4'd0); rd(4'd0, 4'd2); tick();
        check("r0_data", ra_data, 0);
        check("r0_busy", ra_busy, 0);
        check("r0_alloc_err", alloc_err, 0);
        check("r0_wb_err", wb_err, 0);
        check("r0_cnt", busy_cnt, 1);
        check("r0_rb_busy", rb_busy, 1);
        check("nr0_data", ra_data0, 8'hFF);
        check("nr0_busy", ra_busy0, 1);
        check("nr0_wb_err", wb_err0, 1);
        check("nr0_cnt", busy_cnt0, 2);
        idle(); rd(4'd0, 4'd0); tick();
        check("r0_rd_again", ra_data, 0);
        check("nr0_rd_again", rb_data0, 8'hFF);

        idle(); alloc(4'd1); tick();
        idle(); alloc(4'd3); tick();
        check("pre_rst_cnt", busy_cnt, 3);
        check("pre_rst_cnt0", busy_cnt0, 4);
        idle(); reset = 1'b1; alloc(4'd3); wr(4'd5, 8'hEE); rd(4'd2, 4'd1); tick();
        check("mid_rst_ra_data", ra_data, 0);
        check("mid_rst_alloc_err", alloc_err, 0);
        check("mid_rst_cnt", busy_cnt, 0);
        check("mid_rst_cnt0", busy_cnt0, 0);
        idle(); rd(4'd2, 4'd5); tick();
        check("post_rst_ra_busy", ra_busy, 0);
        check("post_rst_ra_data", ra_data, 0);
        check("post_rst_rb_data", rb_data, 0);
        check("post_rst_cnt", busy_cnt, 0);
        check("post_rst_wb_err", wb_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
